// File: rtl/issue_scoreboard.sv
// In-order issue stage: one-entry issue register guarded by a per-register
// pending-write scoreboard with RAW/WAW/serialization hazard detection.
module issue_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_single_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [63:0] out_single_instr,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_cnt
);

    localparam int unsigned NREGS   = 32;
    localparam int unsigned ID_W    = 64;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned CNT_W   = 16;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_eff;
    logic [NREGS-1:0] wb_eff;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pending_nxt;

    logic [IDX_W-1:0] lsb_idx;
    logic             unknown;

    logic cls_r, cls_iarith, cls_load, cls_store, cls_branch;
    logic cls_jal, cls_jalr, cls_lui, cls_auipc, cls_sys;
    logic csr_wr, csr_rs1;
    logic writes_rd, uses_rs1, uses_rs2;
    logic raw1, raw2, waw, serialize, hazard;
    logic accept;

    // Lowest set bit of the ID picks the class, so malformed IDs decode deterministically.
    always_comb begin
        lsb_idx = '0;
        for (int i = ID_W - 1; i >= 0; i--) begin
            if (in_single_instr[i]) begin
                lsb_idx = IDX_W'(i);
            end
        end
    end

    assign unknown = (in_single_instr == '0);

    always_comb begin
        cls_r      = !unknown && (lsb_idx <= 6'd9);
        cls_iarith = !unknown && (lsb_idx >= 6'd10) && (lsb_idx <= 6'd18);
        cls_load   = !unknown && (lsb_idx >= 6'd19) && (lsb_idx <= 6'd23);
        cls_store  = !unknown && (lsb_idx >= 6'd24) && (lsb_idx <= 6'd26);
        cls_branch = !unknown && (lsb_idx >= 6'd27) && (lsb_idx <= 6'd32);
        cls_jal    = !unknown && (lsb_idx == 6'd33);
        cls_jalr   = !unknown && (lsb_idx == 6'd34);
        cls_lui    = !unknown && (lsb_idx == 6'd35);
        cls_auipc  = !unknown && (lsb_idx == 6'd36);
        cls_sys    = !unknown && (lsb_idx >= 6'd37) && (lsb_idx <= 6'd46);
        csr_wr     = !unknown && (lsb_idx >= 6'd41) && (lsb_idx <= 6'd46);
        csr_rs1    = !unknown && (lsb_idx >= 6'd41) && (lsb_idx <= 6'd43);
    end

    always_comb begin
        writes_rd = (cls_r || cls_iarith || cls_load || cls_jal || cls_jalr ||
                     cls_lui || cls_auipc || csr_wr) && (in_rd != 5'd0);
        uses_rs1  = cls_r || cls_iarith || cls_load || cls_store || cls_branch ||
                    cls_jalr || csr_rs1;
        uses_rs2  = cls_r || cls_store || cls_branch;
    end

    // Writebacks landing this cycle release their register for the hazard check.
    always_comb begin
        wb_eff = '0;
        if (wb_valid && !flush && (wb_rd != 5'd0)) begin
            wb_eff = NREGS'(1) << wb_rd;
        end
    end

    assign pending_eff = pending & ~wb_eff;

    always_comb begin
        raw1      = uses_rs1  && pending_eff[in_rs1];
        raw2      = uses_rs2  && pending_eff[in_rs2];
        waw       = writes_rd && pending_eff[in_rd];
        serialize = cls_sys && ((pending_eff != '0) || out_valid);
        hazard    = !unknown && (raw1 || raw2 || waw || serialize);
    end

    assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // A same-cycle set of a register wins over its writeback clear.
    always_comb begin
        set_mask = '0;
        if (accept && writes_rd) begin
            set_mask = NREGS'(1) << in_rd;
        end
        pending_nxt    = (pending & ~wb_eff) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy_mask = pending;

    // Issue register: payload holds its last value once drained or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_illegal      <= 1'b0;
            out_rd           <= '0;
            out_rs1          <= '0;
            out_rs2          <= '0;
            out_single_instr <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            out_illegal      <= unknown;
            out_rd           <= in_rd;
            out_rs1          <= in_rs1;
            out_rs2          <= in_rs2;
            out_single_instr <= in_single_instr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
